blue_filter_cfg_seq: RTL and testbench
======================================

Name: blue_filter_cfg_seq

Overview:
AXI4-Lite master that configures and sequences one blue_filter_ip instance through its S00_AXI register file (4 x 32-bit registers).
- On a start pulse it writes threshold and gain, sets CTRL.run, polls STATUS.done, then clears CTRL.
- Reports busy, done and error to the local control logic.
- Sits between the frame-level controller and the filter slave, in place of the processor/VIP master.

Parameters:
- ADDR_W, 4, AXI address width; matches the filter slave.
- BASE_ADDR, 0, added to every register offset.
- POLL_GAP, 16, idle cycles between STATUS reads; must be >= 1.
- POLL_MAX, 1024, maximum STATUS reads before timeout; must be >= 1.

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; ignored while busy=1
- cfg_thresh  in  32  value for THRESH (offset 0x4); sampled when start is accepted
- cfg_gain  in  32  value for GAIN (offset 0x8); sampled when start is accepted
- busy  out  1  high from accept until done
- done  out  1  one-cycle pulse at end of sequence
- err  out  1  valid with done; 1 = sequence failed
- err_code  out  2  valid with done: 0 = ok, 1 = SLVERR/DECERR response, 2 = poll timeout
- m_axi_awaddr, m_axi_awprot(3), m_axi_awvalid, m_axi_awready(in)
- m_axi_wdata(32), m_axi_wstrb(4), m_axi_wvalid, m_axi_wready(in)
- m_axi_bresp(2, in), m_axi_bvalid(in), m_axi_bready
- m_axi_araddr, m_axi_arprot(3), m_axi_arvalid, m_axi_arready(in)
- m_axi_rdata(32, in), m_axi_rresp(2, in), m_axi_rvalid(in), m_axi_rready

Behaviour:
- Clocking and reset: single clock domain, ACLK. ARESETN is asynchronous and active-low.
- Reset values: all outputs 0; FSM in IDLE; counters 0. Constant outputs: awprot = arprot = 0, wstrb = 4'hF.
- Reset mid-transaction: outputs drop immediately. The slave is reset by the same ARESETN, so no drain is needed.

FSM states:
- IDLE
- WR: awvalid and wvalid asserted together in the same cycle. Each valid drops independently after its own handshake. Exit when both handshakes are done.
- WRESP: bready = 1. On bvalid:
  - bresp != 0 -> FIN with err_code 1.
  - otherwise advance the step.
- RD: arvalid held until arready.
- RRESP: rready = 1. On rvalid:
  - rresp != 0 -> FIN with err_code 1.
  - rdata[0] = 1 -> step 3.
  - poll count reached POLL_MAX -> FIN with err_code 2.
  - otherwise -> GAP.
- GAP: waits POLL_GAP cycles, then -> RD.
- FIN: done = 1 for one cycle, then -> IDLE.

Step sequence:
- step 0: write THRESH.
- step 1: write GAIN.
- step 2: write CTRL (0x0) = 1.
- poll: read STATUS (0xC) until bit0 = 1.
- step 3: write CTRL = 0. After its response -> FIN, err 0.
- On the error paths, CTRL is left as-is; software or the next start overwrites it.

Handshake and timing rules:
- Valids never drop before their handshake; addr/data stay stable while valid.
- The block issues at most one outstanding transaction.
- start accepted in IDLE -> busy = 1 and awvalid = 1 on the next cycle.
- busy drops in the same cycle that done pulses.
- start asserted in the FIN cycle is ignored.
- The poll counter is 11 bits (clog2(POLL_MAX) + 1) and saturates.
- Counters reset on each accepted start.
- Minimum sequence latency: 4 writes x 2 cycles + 1 read x 2 cycles + FIN, with zero-wait slave.

Decomposition:
Package blue_filter_pkg holds:
- register offsets: REG_CTRL = 0x0, REG_THRESH = 0x4, REG_GAIN = 0x8, REG_STATUS = 0xC
- AXI resp codes: OKAY = 2'b00
- state enum seq_state_t
- err_code constants ERR_NONE, ERR_RESP, ERR_TIMEOUT

Natural sub-module: axil_single_master, one AXI4-Lite write/read engine.
- Request interface: req, we, addr, wdata.
- Response interface: ack, rdata, resp.
- blue_filter_cfg_seq keeps only the step/poll FSM.

Test Plan:
1. thresh = 0x80, gain = 0x3, start; zero-wait slave; STATUS bit0 set after 3 reads.
   - Required: writes 0x4 = 0x80, 0x8 = 0x3, 0x0 = 1; 3 reads of 0xC with 16-cycle gaps; then 0x0 = 0.
   - done with err = 0, err_code = 0.
2. Slave returns bresp = 2'b10 on the GAIN write.
   - Required: no CTRL write; done with err = 1, err_code = 1.
3. STATUS never sets, POLL_MAX = 4.
   - Required: exactly 4 reads; done with err = 1, err_code = 2; no CTRL = 0 write.
4. Slave delays awready 5 cycles and wready 2 cycles (independent).
   - Required: valids held stable; one B accepted; sequence completes as in test 1.
5. start pulsed while busy, and again in the FIN cycle.
   - Required: ignored; exactly one sequence and one done pulse.
6. ARESETN dropped during RRESP.
   - Required: all outputs 0 immediately.
   - After release, a new start runs the full sequence from step 0 with the newly sampled cfg values.

Source files
------------

// File: rtl/blue_filter_pkg.sv
// Shared constants for the blue_filter_ip configuration sequencer:
// register map, AXI response codes, state encodings and error codes.
package blue_filter_pkg;

  localparam logic [7:0] REG_CTRL   = 8'h00;
  localparam logic [7:0] REG_THRESH = 8'h04;
  localparam logic [7:0] REG_GAIN   = 8'h08;
  localparam logic [7:0] REG_STATUS = 8'h0C;

  localparam logic [1:0] OKAY = 2'b00;

  typedef logic [2:0] seq_state_t;

  localparam seq_state_t ST_IDLE  = 3'd0;
  localparam seq_state_t ST_WR    = 3'd1;
  localparam seq_state_t ST_WRESP = 3'd2;
  localparam seq_state_t ST_RD    = 3'd3;
  localparam seq_state_t ST_RRESP = 3'd4;
  localparam seq_state_t ST_GAP   = 3'd5;
  localparam seq_state_t ST_FIN   = 3'd6;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_RESP    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

endpackage

// File: rtl/blue_filter_cfg_seq_axil.sv
// Single-outstanding AXI4-Lite master engine: one write or one read per request.
// A new request may be launched in the same cycle the previous response is acknowledged.
module axil_single_master
  import blue_filter_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ack,
  output logic [31:0]       rdata,
  output logic [1:0]        resp,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [2:0]        m_axi_awprot,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [31:0]       m_axi_wdata,
  output logic [3:0]        m_axi_wstrb,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [2:0]        m_axi_arprot,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [31:0]       m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  seq_state_t state;
  logic       launch;
  logic       aw_ok;
  logic       w_ok;

  assign ack    = ((state == ST_WRESP) && m_axi_bvalid) || ((state == ST_RRESP) && m_axi_rvalid);
  assign launch = req && ((state == ST_IDLE) || ack);
  assign aw_ok  = !m_axi_awvalid || m_axi_awready;
  assign w_ok   = !m_axi_wvalid || m_axi_wready;

  assign rdata = m_axi_rdata;
  assign resp  = (state == ST_RRESP) ? m_axi_rresp : m_axi_bresp;

  assign m_axi_bready = (state == ST_WRESP);
  assign m_axi_rready = (state == ST_RRESP);
  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;
  assign m_axi_wstrb  = 4'hF;

  // Channel state and valids; AW and W retire independently, addr/data only change at launch
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state         <= ST_IDLE;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_awaddr  <= {ADDR_W{1'b0}};
      m_axi_wdata   <= 32'd0;
      m_axi_araddr  <= {ADDR_W{1'b0}};
    end else if (launch) begin
      if (we) begin
        state         <= ST_WR;
        m_axi_awvalid <= 1'b1;
        m_axi_wvalid  <= 1'b1;
        m_axi_awaddr  <= addr;
        m_axi_wdata   <= wdata;
      end else begin
        state         <= ST_RD;
        m_axi_arvalid <= 1'b1;
        m_axi_araddr  <= addr;
      end
    end else begin
      case (state)
        ST_WR: begin
          if (m_axi_awready) begin
            m_axi_awvalid <= 1'b0;
          end
          if (m_axi_wready) begin
            m_axi_wvalid <= 1'b0;
          end
          if (aw_ok && w_ok) begin
            state <= ST_WRESP;
          end
        end
        ST_WRESP: begin
          if (m_axi_bvalid) begin
            state <= ST_IDLE;
          end
        end
        ST_RD: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            state         <= ST_RRESP;
          end
        end
        ST_RRESP: begin
          if (m_axi_rvalid) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/blue_filter_cfg_seq.sv
// Configuration sequencer for blue_filter_ip: THRESH, GAIN, CTRL.run, poll STATUS.done,
// then CTRL clear. Bus traffic is delegated to axil_single_master.
module blue_filter_cfg_seq
  import blue_filter_pkg::*;
#(
  parameter int ADDR_W    = 4,
  parameter int BASE_ADDR = 0,
  parameter int POLL_GAP  = 16,
  parameter int POLL_MAX  = 1024
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              start,
  input  logic [31:0]       cfg_thresh,
  input  logic [31:0]       cfg_gain,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [2:0]        m_axi_awprot,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [31:0]       m_axi_wdata,
  output logic [3:0]        m_axi_wstrb,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [2:0]        m_axi_arprot,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [31:0]       m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  localparam int PCW = $clog2(POLL_MAX) + 1;
  localparam int GCW = $clog2(POLL_GAP) + 1;
  localparam logic [PCW-1:0] POLL_LIMIT = PCW'(POLL_MAX);
  localparam logic [GCW-1:0] GAP_LAST   = GCW'(POLL_GAP - 1);

  seq_state_t        state;
  seq_state_t        nxt_state;
  logic [1:0]        step;
  logic [1:0]        nxt_step;
  logic [31:0]       gain_q;
  logic [PCW-1:0]    poll_cnt;
  logic [GCW-1:0]    gap_cnt;
  logic              fin;
  logic [1:0]        fin_code;
  logic              accept;
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              ack;
  logic [31:0]       rd_data;
  logic [1:0]        resp;

  function automatic logic [ADDR_W-1:0] reg_addr(input logic [7:0] off);
    return ADDR_W'(BASE_ADDR + int'(off));
  endfunction

  assign accept = (state == ST_IDLE) && start;

  // Step/poll decisions; the next request is issued in the same cycle the previous one is acked
  always_comb begin
    req       = 1'b0;
    we        = 1'b1;
    addr      = reg_addr(REG_CTRL);
    wdata     = 32'd0;
    nxt_state = state;
    nxt_step  = step;
    fin       = 1'b0;
    fin_code  = ERR_NONE;
    case (state)
      ST_IDLE: begin
        if (start) begin
          req       = 1'b1;
          addr      = reg_addr(REG_THRESH);
          wdata     = cfg_thresh;
          nxt_step  = 2'd0;
          nxt_state = ST_WR;
        end else begin
          nxt_state = ST_IDLE;
        end
      end
      ST_WR: begin
        if (ack && (resp != OKAY)) begin
          fin       = 1'b1;
          fin_code  = ERR_RESP;
          nxt_state = ST_FIN;
        end else if (ack) begin
          case (step)
            2'd0: begin
              req      = 1'b1;
              addr     = reg_addr(REG_GAIN);
              wdata    = gain_q;
              nxt_step = 2'd1;
            end
            2'd1: begin
              req      = 1'b1;
              addr     = reg_addr(REG_CTRL);
              wdata    = 32'd1;
              nxt_step = 2'd2;
            end
            2'd2: begin
              req       = 1'b1;
              we        = 1'b0;
              addr      = reg_addr(REG_STATUS);
              nxt_state = ST_RD;
            end
            default: begin
              fin       = 1'b1;
              fin_code  = ERR_NONE;
              nxt_state = ST_FIN;
            end
          endcase
        end else begin
          nxt_state = ST_WR;
        end
      end
      ST_RD: begin
        if (ack && (resp != OKAY)) begin
          fin       = 1'b1;
          fin_code  = ERR_RESP;
          nxt_state = ST_FIN;
        end else if (ack && rd_data[0]) begin
          req       = 1'b1;
          addr      = reg_addr(REG_CTRL);
          wdata     = 32'd0;
          nxt_step  = 2'd3;
          nxt_state = ST_WR;
        end else if (ack && (poll_cnt >= POLL_LIMIT)) begin
          fin       = 1'b1;
          fin_code  = ERR_TIMEOUT;
          nxt_state = ST_FIN;
        end else if (ack) begin
          nxt_state = ST_GAP;
        end else begin
          nxt_state = ST_RD;
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          req       = 1'b1;
          we        = 1'b0;
          addr      = reg_addr(REG_STATUS);
          nxt_state = ST_RD;
        end else begin
          nxt_state = ST_GAP;
        end
      end
      ST_FIN: begin
        nxt_state = ST_IDLE;
      end
      default: begin
        nxt_state = ST_IDLE;
      end
    endcase
  end

  // Sequencer state, counters and status outputs; busy falls as done rises
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state    <= ST_IDLE;
      step     <= 2'd0;
      gain_q   <= 32'd0;
      poll_cnt <= {PCW{1'b0}};
      gap_cnt  <= {GCW{1'b0}};
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      state   <= nxt_state;
      step    <= nxt_step;
      gap_cnt <= (state == ST_GAP) ? gap_cnt + GCW'(1) : {GCW{1'b0}};
      if (accept) begin
        gain_q   <= cfg_gain;
        busy     <= 1'b1;
        poll_cnt <= {PCW{1'b0}};
      end else if (req && !we && (poll_cnt != {PCW{1'b1}})) begin
        poll_cnt <= poll_cnt + PCW'(1);
      end
      if (fin) begin
        done     <= 1'b1;
        busy     <= 1'b0;
        err      <= (fin_code != ERR_NONE);
        err_code <= fin_code;
      end else if (state == ST_FIN) begin
        done     <= 1'b0;
        err      <= 1'b0;
        err_code <= ERR_NONE;
      end
    end
  end

  axil_single_master #(
    .ADDR_W(ADDR_W)
  ) u_axil (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .req           (req),
    .we            (we),
    .addr          (addr),
    .wdata         (wdata),
    .ack           (ack),
    .rdata         (rd_data),
    .resp          (resp),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awprot  (m_axi_awprot),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arprot  (m_axi_arprot),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready)
  );

endmodule

// File: tb/tb_blue_filter_cfg_seq.sv
// Directed bench for blue_filter_cfg_seq with a behavioural AXI4-Lite filter slave
// that logs every write/read and flags valid/payload instability.
module tb_blue_filter_cfg_seq;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        start = 1'b0;
  logic [31:0] cfg_thresh = 32'd0;
  logic [31:0] cfg_gain = 32'd0;
  logic        busy, done, err;
  logic [1:0]  err_code;
  logic [3:0]  m_axi_awaddr, m_axi_araddr;
  logic [2:0]  m_axi_awprot, m_axi_arprot;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [31:0] m_axi_wdata, m_axi_rdata;
  logic [3:0]  m_axi_wstrb;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;

  blue_filter_cfg_seq #(.ADDR_W(4), .BASE_ADDR(0), .POLL_GAP(16), .POLL_MAX(4)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .cfg_thresh(cfg_thresh), .cfg_gain(cfg_gain),
    .busy(busy), .done(done), .err(err), .err_code(err_code),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;

  int   aw_delay = 0, w_delay = 0, status_after = 0, err_addr = -1;
  logic log_clr = 1'b0;

  int          aw_wait, w_wait, wr_n, b_n, rd_n, stab_err, done_cnt, cyc;
  logic        got_aw, got_w, p_aw, p_w, p_ar;
  logic [3:0]  aw_q, p_awaddr, p_araddr;
  logic [31:0] w_q, p_wdata;
  logic [3:0]  wr_addr[8];
  logic [31:0] wr_data[8];
  logic [3:0]  rd_addr[8];
  int          ar_cyc[8], r_cyc[8];
  logic [3:0]  exp_a[4];
  logic [31:0] exp_d[4];

  assign m_axi_awready = m_axi_awvalid && (aw_wait >= aw_delay);
  assign m_axi_wready  = m_axi_wvalid && (w_wait >= w_delay);
  assign m_axi_arready = m_axi_arvalid;
  assign m_axi_rresp   = 2'b00;

  // Slave model, transaction log and stability monitor
  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_wait <= 0; w_wait <= 0; got_aw <= 1'b0; got_w <= 1'b0;
      m_axi_bvalid <= 1'b0; m_axi_bresp <= 2'b00; m_axi_rvalid <= 1'b0; m_axi_rdata <= 32'd0;
      wr_n <= 0; b_n <= 0; rd_n <= 0; stab_err <= 0; done_cnt <= 0; cyc <= 0;
      p_aw <= 1'b0; p_w <= 1'b0; p_ar <= 1'b0;
    end else begin
      cyc     <= cyc + 1;
      aw_wait <= (m_axi_awvalid && !m_axi_awready) ? aw_wait + 1 : 0;
      w_wait  <= (m_axi_wvalid && !m_axi_wready) ? w_wait + 1 : 0;
      if (m_axi_awvalid && m_axi_awready) begin got_aw <= 1'b1; aw_q <= m_axi_awaddr; end
      if (m_axi_wvalid && m_axi_wready) begin got_w <= 1'b1; w_q <= m_axi_wdata; end
      if (m_axi_bvalid && m_axi_bready) begin m_axi_bvalid <= 1'b0; b_n <= b_n + 1; end
      if ((got_aw || (m_axi_awvalid && m_axi_awready)) && (got_w || (m_axi_wvalid && m_axi_wready))) begin
        m_axi_bvalid <= 1'b1;
        m_axi_bresp  <= (int'(got_aw ? aw_q : m_axi_awaddr) == err_addr) ? 2'b10 : 2'b00;
        if (wr_n < 8) begin
          wr_addr[wr_n] <= got_aw ? aw_q : m_axi_awaddr;
          wr_data[wr_n] <= got_w ? w_q : m_axi_wdata;
        end
        wr_n <= wr_n + 1; got_aw <= 1'b0; got_w <= 1'b0;
      end
      if (m_axi_arvalid && m_axi_arready) begin
        m_axi_rvalid <= 1'b1;
        m_axi_rdata  <= {31'd0, ((status_after != 0) && (rd_n + 1 >= status_after))};
        if (rd_n < 8) begin rd_addr[rd_n] <= m_axi_araddr; ar_cyc[rd_n] <= cyc; end
        rd_n <= rd_n + 1;
      end
      if (m_axi_rvalid && m_axi_rready) begin
        m_axi_rvalid <= 1'b0;
        if (rd_n >= 1 && rd_n <= 8) r_cyc[rd_n-1] <= cyc;
      end
      p_aw <= m_axi_awvalid && !m_axi_awready; p_awaddr <= m_axi_awaddr;
      p_w  <= m_axi_wvalid && !m_axi_wready;   p_wdata  <= m_axi_wdata;
      p_ar <= m_axi_arvalid && !m_axi_arready; p_araddr <= m_axi_araddr;
      if ((p_aw && (!m_axi_awvalid || m_axi_awaddr != p_awaddr)) ||
          (p_w && (!m_axi_wvalid || m_axi_wdata != p_wdata)) ||
          (p_ar && (!m_axi_arvalid || m_axi_araddr != p_araddr)))
        stab_err <= stab_err + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (log_clr) begin wr_n <= 0; b_n <= 0; rd_n <= 0; stab_err <= 0; done_cnt <= 0; end
    end
  end

  task automatic clear_log;
    @(negedge ACLK); log_clr = 1'b1;
    @(negedge ACLK); log_clr = 1'b0;
  endtask

  task automatic pulse_start(input logic [31:0] t, input logic [31:0] g);
    cfg_thresh = t; cfg_gain = g; start = 1'b1;
    @(negedge ACLK); start = 1'b0;
  endtask

  task automatic wait_done(output logic ok, output logic e, output logic [1:0] c, output logic b);
    ok = 1'b0; e = 1'b0; c = 2'd0; b = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (done) begin ok = 1'b1; e = err; c = err_code; b = busy; break; end
      @(negedge ACLK);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge ACLK);
    checks++; if ({busy, done, err, err_code} !== 5'd0) begin errors++; $display("FAIL reset_status: got %b want 00000", {busy, done, err, err_code}); end
    checks++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready} !== 5'd0) begin errors++; $display("FAIL reset_axi: got %b want 00000", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}); end
    ARESETN = 1'b1;
    @(negedge ACLK);
    checks++; if ({busy, done, m_axi_awvalid, m_axi_arvalid} !== 4'd0) begin errors++; $display("FAIL idle_after_reset: got %b want 0000", {busy, done, m_axi_awvalid, m_axi_arvalid}); end
    checks++; if ({m_axi_awprot, m_axi_arprot, m_axi_wstrb} !== {3'd0, 3'd0, 4'hF}) begin errors++; $display("FAIL const_outputs: got %h want 00f", {m_axi_awprot, m_axi_arprot, m_axi_wstrb}); end
  endtask

  task automatic test_basic;
    logic ok, e, b; logic [1:0] c;
    clear_log(); status_after = 3;
    pulse_start(32'h80, 32'h3);
    checks++; if ({busy, m_axi_awvalid, m_axi_wvalid} !== 3'b111) begin errors++; $display("FAIL basic_accept: got %b want 111", {busy, m_axi_awvalid, m_axi_wvalid}); end
    checks++; if ({m_axi_awaddr, m_axi_wdata} !== {4'h4, 32'h80}) begin errors++; $display("FAIL basic_first_aw: got %h/%h want 4/80", m_axi_awaddr, m_axi_wdata); end
    wait_done(ok, e, c, b);
    checks++; if ({ok, e, c, b} !== 5'b10000) begin errors++; $display("FAIL basic_done: got ok=%b err=%b code=%0d busy=%b want 1 0 0 0", ok, e, c, b); end
    checks++; if (wr_n !== 4 || rd_n !== 3 || b_n !== 4) begin errors++; $display("FAIL basic_counts: got wr=%0d rd=%0d b=%0d want 4 3 4", wr_n, rd_n, b_n); end
    exp_a = '{4'h4, 4'h8, 4'h0, 4'h0}; exp_d = '{32'h80, 32'h3, 32'h1, 32'h0};
    for (int i = 0; i < 4; i++) begin
      checks++; if (wr_addr[i] !== exp_a[i] || wr_data[i] !== exp_d[i]) begin errors++; $display("FAIL basic_write%0d: got %h=%h want %h=%h", i, wr_addr[i], wr_data[i], exp_a[i], exp_d[i]); end
    end
    for (int i = 0; i < 3; i++) begin
      checks++; if (rd_addr[i] !== 4'hC) begin errors++; $display("FAIL basic_read%0d_addr: got %h want c", i, rd_addr[i]); end
    end
    for (int i = 0; i < 2; i++) begin
      checks++; if (ar_cyc[i+1] - r_cyc[i] - 1 !== 16) begin errors++; $display("FAIL basic_gap%0d: got %0d want 16", i, ar_cyc[i+1] - r_cyc[i] - 1); end
    end
  endtask

  task automatic test_bresp_err;
    logic ok, e, b; logic [1:0] c;
    clear_log(); status_after = 3; err_addr = 8;
    pulse_start(32'h10, 32'h20);
    wait_done(ok, e, c, b);
    err_addr = -1;
    checks++; if ({ok, e, c} !== 4'b1101) begin errors++; $display("FAIL bresp_done: got ok=%b err=%b code=%0d want 1 1 1", ok, e, c); end
    checks++; if (wr_n !== 2 || rd_n !== 0) begin errors++; $display("FAIL bresp_no_ctrl: got wr=%0d rd=%0d want 2 0", wr_n, rd_n); end
    checks++; if (wr_addr[1] !== 4'h8 || wr_data[1] !== 32'h20) begin errors++; $display("FAIL bresp_gain_write: got %h=%h want 8=20", wr_addr[1], wr_data[1]); end
  endtask

  task automatic test_timeout;
    logic ok, e, b; logic [1:0] c;
    clear_log(); status_after = 0;
    pulse_start(32'h1, 32'h2);
    wait_done(ok, e, c, b);
    checks++; if ({ok, e, c} !== 4'b1110) begin errors++; $display("FAIL timeout_done: got ok=%b err=%b code=%0d want 1 1 2", ok, e, c); end
    checks++; if (rd_n !== 4) begin errors++; $display("FAIL timeout_reads: got %0d want 4", rd_n); end
    checks++; if (wr_n !== 3 || wr_addr[2] !== 4'h0 || wr_data[2] !== 32'h1) begin errors++; $display("FAIL timeout_writes: got n=%0d last %h=%h want 3 0=1", wr_n, wr_addr[2], wr_data[2]); end
  endtask

  task automatic test_wait_states;
    logic ok, e, b; logic [1:0] c;
    clear_log(); status_after = 3; aw_delay = 5; w_delay = 2;
    pulse_start(32'h80, 32'h3);
    wait_done(ok, e, c, b);
    aw_delay = 0; w_delay = 0;
    checks++; if ({ok, e, c} !== 4'b1000) begin errors++; $display("FAIL wait_done: got ok=%b err=%b code=%0d want 1 0 0", ok, e, c); end
    checks++; if (stab_err !== 0) begin errors++; $display("FAIL wait_stable: got %0d violations want 0", stab_err); end
    checks++; if (wr_n !== 4 || b_n !== 4 || rd_n !== 3) begin errors++; $display("FAIL wait_counts: got wr=%0d b=%0d rd=%0d want 4 4 3", wr_n, b_n, rd_n); end
    exp_a = '{4'h4, 4'h8, 4'h0, 4'h0}; exp_d = '{32'h80, 32'h3, 32'h1, 32'h0};
    for (int i = 0; i < 4; i++) begin
      checks++; if (wr_addr[i] !== exp_a[i] || wr_data[i] !== exp_d[i]) begin errors++; $display("FAIL wait_write%0d: got %h=%h want %h=%h", i, wr_addr[i], wr_data[i], exp_a[i], exp_d[i]); end
    end
  endtask

  task automatic test_start_ignored;
    logic seen;
    clear_log(); status_after = 3; seen = 1'b0;
    pulse_start(32'h11, 32'h22);
    repeat (3) @(negedge ACLK);
    pulse_start(32'h99, 32'h98);
    for (int i = 0; i < 2000; i++) begin
      if (done) begin seen = 1'b1; cfg_thresh = 32'h77; cfg_gain = 32'h66; start = 1'b1; break; end
      @(negedge ACLK);
    end
    @(negedge ACLK); start = 1'b0;
    repeat (40) @(negedge ACLK);
    checks++; if (!seen || done_cnt !== 1) begin errors++; $display("FAIL ignore_done_count: got seen=%b count=%0d want 1 1", seen, done_cnt); end
    checks++; if (busy !== 1'b0 || wr_n !== 4) begin errors++; $display("FAIL ignore_no_restart: got busy=%b wr=%0d want 0 4", busy, wr_n); end
    exp_a = '{4'h4, 4'h8, 4'h0, 4'h0}; exp_d = '{32'h11, 32'h22, 32'h1, 32'h0};
    for (int i = 0; i < 4; i++) begin
      checks++; if (wr_addr[i] !== exp_a[i] || wr_data[i] !== exp_d[i]) begin errors++; $display("FAIL ignore_write%0d: got %h=%h want %h=%h", i, wr_addr[i], wr_data[i], exp_a[i], exp_d[i]); end
    end
  endtask

  task automatic test_reset_mid;
    logic ok, e, b, seen; logic [1:0] c;
    clear_log(); status_after = 0; seen = 1'b0;
    pulse_start(32'hAA, 32'hBB);
    for (int i = 0; i < 200; i++) begin
      if (m_axi_rready) begin seen = 1'b1; break; end
      @(negedge ACLK);
    end
    checks++; if (!seen) begin errors++; $display("FAIL rst_reach_rresp: got no rready want rready within 200 cycles"); end
    ARESETN = 1'b0;
    #1;
    checks++; if ({busy, done, err, err_code, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready} !== 10'd0) begin errors++; $display("FAIL rst_mid_ctrl: got %b want 0", {busy, done, err, err_code, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}); end
    checks++; if ({m_axi_awaddr, m_axi_araddr, m_axi_wdata} !== 40'd0) begin errors++; $display("FAIL rst_mid_payload: got %h want 0", {m_axi_awaddr, m_axi_araddr, m_axi_wdata}); end
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    clear_log(); status_after = 3;
    pulse_start(32'h55, 32'h7);
    wait_done(ok, e, c, b);
    checks++; if ({ok, e, c} !== 4'b1000 || wr_n !== 4) begin errors++; $display("FAIL rst_rerun: got ok=%b err=%b code=%0d wr=%0d want 1 0 0 4", ok, e, c, wr_n); end
    exp_a = '{4'h4, 4'h8, 4'h0, 4'h0}; exp_d = '{32'h55, 32'h7, 32'h1, 32'h0};
    for (int i = 0; i < 4; i++) begin
      checks++; if (wr_addr[i] !== exp_a[i] || wr_data[i] !== exp_d[i]) begin errors++; $display("FAIL rst_write%0d: got %h=%h want %h=%h", i, wr_addr[i], wr_data[i], exp_a[i], exp_d[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bresp_err();
    test_timeout();
    test_wait_states();
    test_start_ignored();
    test_reset_mid();
    repeat (3) @(negedge ACLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
